// File: rtl/packet_framer_pkg.sv
// Shared defaults and FSM state encoding for the packet framer.
package framer_pkg;

    localparam int unsigned DefPacketSize = 1024;
    localparam logic [15:0] DefSyncHead   = 16'hA5A5;
    localparam logic [15:0] DefSyncTail   = 16'h5A5A;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPayload = 2'd1,
        StTrailer = 2'd2
    } framer_state_e;

endpackage

// File: rtl/packet_framer_if.sv
// Sample stream in, framed word stream out, plus downstream FIFO flags.
interface packet_framer_if;

    logic [15:0] sample;
    logic        sample_valid;
    logic        fifo_almost_full;
    logic        fifo_full;
    logic [31:0] data_out;
    logic        data_out_valid;

    // master: the framer; slave: the sample source / downstream gateway side
    modport master (
        input  sample,
        input  sample_valid,
        input  fifo_almost_full,
        input  fifo_full,
        output data_out,
        output data_out_valid
    );

    modport slave (
        output sample,
        output sample_valid,
        output fifo_almost_full,
        output fifo_full,
        input  data_out,
        input  data_out_valid
    );

endinterface

// File: rtl/packet_framer.sv
// Packs 16-bit samples into 32-bit words framed as header / payload / trailer.
module packet_framer
    import framer_pkg::*;
#(
    parameter int unsigned PACKET_SIZE = DefPacketSize,
    parameter logic [15:0] SYNC_HEAD   = DefSyncHead,
    parameter logic [15:0] SYNC_TAIL   = DefSyncTail
) (
    input  logic                   data_in_clk,
    input  logic                   rst,
    input  logic                   enable,
    packet_framer_if.master        bus,
    output logic [15:0]            seq_num,
    output logic [15:0]            drop_count,
    output logic                   overflow_failure
);

    localparam int unsigned    CntW     = $clog2(PACKET_SIZE);
    // index of the final payload word within the packet
    localparam logic [CntW-1:0] LastWord = CntW'(PACKET_SIZE - 3);

    framer_state_e   state_q, state_d;
    logic [CntW-1:0] word_cnt_q, word_cnt_d;
    logic            have_low_q, have_low_d;
    logic [15:0]     low_q, low_d;
    logic [15:0]     csum_q, csum_d;
    logic [15:0]     seq_q, seq_d;
    logic [15:0]     drop_q, drop_d;
    logic            ovf_q, ovf_d;
    logic [31:0]     dout_q, dout_d;
    logic            dvalid_q, dvalid_d;
    logic            drop_inc;

    // Next-state and output word selection.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        have_low_d = have_low_q;
        low_d      = low_q;
        csum_d     = csum_q;
        seq_d      = seq_q;
        dout_d     = dout_q;
        dvalid_d   = 1'b0;
        drop_inc   = 1'b0;
        ovf_d      = ovf_q | (dvalid_q & bus.fifo_full);

        unique case (state_q)
            StIdle: begin
                if (bus.sample_valid) begin
                    if (enable && !bus.fifo_almost_full) begin
                        dout_d     = {SYNC_HEAD, seq_q};
                        dvalid_d   = 1'b1;
                        low_d      = bus.sample;
                        have_low_d = 1'b1;
                        // checksum restarts with the first payload sample
                        csum_d     = bus.sample;
                        word_cnt_d = '0;
                        state_d    = StPayload;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            StPayload: begin
                if (bus.sample_valid) begin
                    csum_d = csum_q ^ bus.sample;
                    if (have_low_q) begin
                        dout_d     = {bus.sample, low_q};
                        dvalid_d   = 1'b1;
                        have_low_d = 1'b0;
                        word_cnt_d = word_cnt_q + 1'b1;
                        if (word_cnt_q == LastWord) begin
                            state_d = StTrailer;
                        end
                    end else begin
                        low_d      = bus.sample;
                        have_low_d = 1'b1;
                    end
                end
            end
            StTrailer: begin
                dout_d   = {SYNC_TAIL, csum_q};
                dvalid_d = 1'b1;
                seq_d    = seq_q + 16'd1;
                state_d  = StIdle;
                drop_inc = bus.sample_valid;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Saturating drop counter increment.
    always_comb begin
        drop_d = drop_q;
        if (drop_inc && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge data_in_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            have_low_q <= 1'b0;
            low_q      <= '0;
            csum_q     <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
            ovf_q      <= 1'b0;
            dout_q     <= '0;
            dvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            have_low_q <= have_low_d;
            low_q      <= low_d;
            csum_q     <= csum_d;
            seq_q      <= seq_d;
            drop_q     <= drop_d;
            ovf_q      <= ovf_d;
            dout_q     <= dout_d;
            dvalid_q   <= dvalid_d;
        end
    end

    assign bus.data_out       = dout_q;
    assign bus.data_out_valid = dvalid_q;
    assign seq_num            = seq_q;
    assign drop_count         = drop_q;
    assign overflow_failure   = ovf_q;

endmodule
